instruction_fetch_unit: RTL
===========================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have port: clock  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high; sampled on rising edge of clock only.
REQ-003 SHALL have port: pc_in  input  32  current PC from the program counter register.
REQ-004 SHALL have port: next_pc  output  32  combinational next PC driven into the program counter register input.
REQ-005 SHALL have ports: imem_req output 1, imem_addr output 32, imem_ready input 1; request accepted when imem_req && imem_ready.
REQ-006 SHALL have ports: imem_rvalid input 1, imem_rdata input 32; one response per accepted request, at least 1 cycle after acceptance.
REQ-007 SHALL have ports: instr_out output 32, instr_valid output 1, decode_ready input 1; instruction consumed when instr_valid && decode_ready.
REQ-008 SHALL have ports: jump input 1, jump_target input 32, branch_taken input 1, branch_target input 32; sampled only in the consume cycle.
REQ-009 SHALL have ports: flush input 1, flush_target input 32; honoured in any state.
REQ-010 SHALL have port: fetch_fault output 1  sticky misaligned-PC indication.

Function
REQ-011 SHALL implement states FETCH, WAIT, HAVE, DRAIN, FAULT.
REQ-012 FETCH: imem_req=1, imem_addr=pc_in; on imem_ready -> WAIT; otherwise remain.
REQ-013 WAIT: imem_req=0; on imem_rvalid capture imem_rdata into instr_out register -> HAVE.
REQ-014 HAVE: instr_valid=1, instr_out stable; on decode_ready -> FETCH; otherwise hold.
REQ-015 next_pc SHALL equal pc_in (hold) in every cycle except consume, flush, and reset cycles.
REQ-016 In the consume cycle next_pc SHALL be jump_target if jump, else branch_target if branch_taken, else pc_in+4 (mod 2^32, wrap FFFFFFFC->00000000).
REQ-017 flush SHALL override every other next_pc source: next_pc=flush_target in that cycle.
REQ-018 flush in FETCH or HAVE: instr_valid cleared next cycle, state -> FETCH; if flush coincides with imem_ready in FETCH, the accepted request SHALL be discarded via DRAIN.
REQ-019 flush in WAIT without imem_rvalid -> DRAIN; flush in WAIT with imem_rvalid -> FETCH, response dropped.
REQ-020 DRAIN: imem_req=0, instr_valid=0; on imem_rvalid discard data -> FETCH; further flush in DRAIN updates next_pc only.
REQ-021 flush in the consume cycle SHALL win over jump/branch/pc+4.
REQ-022 FETCH with pc_in[1:0]!=0: no request issued, fetch_fault=1 next cycle, state -> FAULT.
REQ-023 FAULT: imem_req=0, instr_valid=0, next_pc=pc_in; exit only by flush with aligned flush_target -> FETCH, fetch_fault cleared.
REQ-024 At most one outstanding imem request at any time.
REQ-025 Minimum throughput with 0-wait memory and decode_ready=1: one instruction per 3 cycles (FETCH, WAIT, HAVE).

Reset
REQ-026 In a reset cycle next_pc SHALL be 32'h00000000 regardless of other inputs.
REQ-027 After reset: state=FETCH, instr_valid=0, instr_out=0, fetch_fault=0, imem_req=0 during reset cycle.
REQ-028 Reset mid-WAIT/DRAIN SHALL abandon the outstanding request; a later imem_rvalid arriving in FETCH SHALL be ignored.

Verification
REQ-029 reset, pc_in=0, imem_ready=1, rdata=0x00A00093 one cycle later, decode_ready=1 -> instr_out=0x00A00093, next_pc=0x4 in consume cycle.
REQ-030 HAVE with decode_ready=0 for 5 cycles -> instr_valid=1, instr_out stable, next_pc=pc_in throughout.
REQ-031 consume with jump=1 (0x100) and branch_taken=1 (0x200) -> next_pc=0x100; with flush=1 (0x300) also -> next_pc=0x300.
REQ-032 flush in WAIT, rvalid 2 cycles later -> DRAIN, response discarded, instr_valid stays 0, next request addr=flush_target.
REQ-033 pc_in=0x00000002 in FETCH -> no imem_req, fetch_fault=1; flush to 0x40 -> fetch_fault=0, request at 0x40.
REQ-034 pc_in=0xFFFFFFFC consumed, no redirect -> next_pc=0x00000000.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// Bundle of the fetch unit's signals: the PC register link, the instruction
// memory request/response channel, the decode handshake, the redirect
// inputs and the fault flag.
// master = the fetch unit, slave = the surrounding core and memory.
interface instruction_fetch_unit_if;
    logic [31:0] pc_in;
    logic [31:0] next_pc;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic [31:0] instr_out;
    logic        instr_valid;
    logic        decode_ready;

    logic        jump;
    logic [31:0] jump_target;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        flush;
    logic [31:0] flush_target;

    logic        fetch_fault;

    modport master (
        input  pc_in, imem_ready, imem_rvalid, imem_rdata, decode_ready,
               jump, jump_target, branch_taken, branch_target,
               flush, flush_target,
        output next_pc, imem_req, imem_addr, instr_out, instr_valid,
               fetch_fault
    );

    modport slave (
        output pc_in, imem_ready, imem_rvalid, imem_rdata, decode_ready,
               jump, jump_target, branch_taken, branch_target,
               flush, flush_target,
        input  next_pc, imem_req, imem_addr, instr_out, instr_valid,
               fetch_fault
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Single-outstanding instruction fetch unit.
// It fetches one word at pc_in, presents it to decode and computes next_pc,
// which the external PC register loads.
// A flush can redirect fetch in any state. Any response still owed by memory
// for an abandoned request is absorbed in DRAIN.
//
// state | meaning
// FETCH | request at pc_in (aligned) waiting for imem_ready
// WAIT  | request accepted, waiting for imem_rvalid
// HAVE  | instruction held for decode until decode_ready
// DRAIN | discarding the response of an abandoned request
// FAULT | misaligned PC seen; parked until flush to an aligned target
module instruction_fetch_unit (
    input  logic                           i_clock,
    input  logic                           i_reset,
    instruction_fetch_unit_if.master       bus
);
    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_WAIT  = 3'd1,
        S_HAVE  = 3'd2,
        S_DRAIN = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t      r_state;
    logic [31:0] r_instr_out;
    logic        r_instr_valid;
    logic        r_fetch_fault;

    logic        w_aligned;
    logic        w_req;
    logic        w_accept;
    logic        w_consume;
    logic [31:0] w_next_pc;

    // A request is only driven for an aligned PC and never during reset.
    assign w_aligned = (bus.pc_in[1:0] == 2'b00);
    assign w_req     = (r_state == S_FETCH) && w_aligned && !i_reset;
    assign w_accept  = w_req && bus.imem_ready;
    assign w_consume = r_instr_valid && bus.decode_ready;

    // Next-PC priority: reset, flush, then the consume-cycle redirect; otherwise hold.
    always_comb begin
        w_next_pc = bus.pc_in;
        if (i_reset) begin
            w_next_pc = 32'h0000_0000;
        end else if (bus.flush) begin
            w_next_pc = bus.flush_target;
        end else if (w_consume) begin
            if (bus.jump)
                w_next_pc = bus.jump_target;
            else if (bus.branch_taken)
                w_next_pc = bus.branch_target;
            else
                w_next_pc = bus.pc_in + 32'd4;
        end
    end

    // Fetch sequencing FSM with registered instruction, valid and fault outputs.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= S_FETCH;
            r_instr_out   <= 32'h0000_0000;
            r_instr_valid <= 1'b0;
            r_fetch_fault <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (bus.flush) begin
                        // The request accepted in this cycle still owes a response.
                        r_state <= w_accept ? S_DRAIN : S_FETCH;
                    end else if (!w_aligned) begin
                        r_state       <= S_FAULT;
                        r_fetch_fault <= 1'b1;
                    end else if (w_accept) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.flush) begin
                        r_state <= bus.imem_rvalid ? S_FETCH : S_DRAIN;
                    end else if (bus.imem_rvalid) begin
                        r_instr_out   <= bus.imem_rdata;
                        r_instr_valid <= 1'b1;
                        r_state       <= S_HAVE;
                    end
                end
                S_HAVE: begin
                    if (bus.flush || bus.decode_ready) begin
                        r_instr_valid <= 1'b0;
                        r_state       <= S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (bus.imem_rvalid)
                        r_state <= S_FETCH;
                end
                S_FAULT: begin
                    if (bus.flush && (bus.flush_target[1:0] == 2'b00)) begin
                        r_fetch_fault <= 1'b0;
                        r_state       <= S_FETCH;
                    end
                end
                default: begin
                    r_state       <= S_FETCH;
                    r_instr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.next_pc     = w_next_pc;
    assign bus.imem_req    = w_req;
    assign bus.imem_addr   = bus.pc_in;
    assign bus.instr_out   = r_instr_out;
    assign bus.instr_valid = r_instr_valid;
    assign bus.fetch_fault = r_fetch_fault;
endmodule
